round_judge: RTL and testbench
==============================

# round_judge

Parametrised round-judgement block for the quadrant-guessing game. Each round it compares the player's selected quadrant against the random target once, at the judge step of the step sequencer. It keeps a saturating score, a win streak and a lives counter, and raises a sticky game-over when lives run out. It sits between the step sequencer / random-quadrant generator and the VGA display logic, which renders win, finish, score and lives.

## Interface
Parameters:
- SEL_W, 3: width of the selection and target codes.
- NUM_SEL, 4: number of valid quadrants; codes >= NUM_SEL are invalid.
- STEP_W, 4: width of the step code.
- JUDGE_STEP, 7: step value that triggers judgement.
- CLEAR_STEP, 0: step value that starts a new round.
- LIVES, 3: lives at game start; range 1..15.
- SCORE_W, 8: width of the score and streak counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- step  in  STEP_W  current sequencer step.
- icuadrante  in  SEL_W  player selection.
- cuadranterandom  in  SEL_W  random target.
- new_game  in  1  one-cycle pulse that restarts the game.
- win  out  1  level: this round was won.
- finish  out  1  level: this round was lost, or the game is over.
- round_rst  out  1  one-cycle pulse at each round start.
- invalid_sel  out  1  one-cycle pulse: judged selection was out of range.
- score  out  SCORE_W  total rounds won, saturating.
- streak  out  SCORE_W  consecutive wins, saturating.
- lives_left  out  4  remaining lives.
- game_over  out  1  sticky until new_game or rst.

## Operation
- step is registered into step_q each cycle; step_q resets to CLEAR_STEP.
- judge_evt = (step==JUDGE_STEP) && (step_q!=JUDGE_STEP).
- clear_evt = (step==CLEAR_STEP) && (step_q!=CLEAR_STEP).
- Only step edges act; holding a step value does nothing further.
- FSM states: PLAY, RESULT, OVER. Reset state is PLAY.
- PLAY, judge_evt with hit (icuadrante==cuadranterandom and icuadrante<NUM_SEL):
  - win<=1, score+1 (saturating), streak+1 (saturating); go to RESULT.
- PLAY, judge_evt with miss:
  - finish<=1, streak<=0, lives_left-1.
  - invalid_sel pulses if icuadrante>=NUM_SEL, including when the target is also out of range.
  - If lives_left was 1: lives_left<=0, game_over<=1, go to OVER. Otherwise go to RESULT.
- RESULT, judge_evt: ignored, one judgement per round.
- RESULT, clear_evt: win<=0, finish<=0, round_rst pulses, go to PLAY.
- PLAY, clear_evt: round_rst pulses; win and finish are already 0.
- OVER: judge_evt and clear_evt are ignored; finish stays 1, win stays 0, round_rst does not pulse.
- new_game in any state:
  - score<=0, streak<=0, lives_left<=LIVES, win<=0, finish<=0, game_over<=0, round_rst pulses, go to PLAY.
  - new_game has priority over a judge_evt or clear_evt in the same cycle; those events are dropped.
- score and streak hold at 2^SCORE_W-1 and do not wrap.
- judge_evt and clear_evt cannot coincide because JUDGE_STEP != CLEAR_STEP; this is required of the parameters.

## Timing
- Reset values: win=0, finish=0, round_rst=0, invalid_sel=0, score=0, streak=0, lives_left=LIVES, game_over=0, state=PLAY, step_q=CLEAR_STEP.
- Reset mid-round discards all state immediately (asynchronous). The first clear_evt after reset needs step to leave CLEAR_STEP and return.
- All outputs are registered.
- Latency: an event sampled at rising edge N updates outputs at edge N; they are visible in cycle N+1.
- icuadrante and cuadranterandom are sampled only at the judge_evt edge.
- round_rst and invalid_sel are high for exactly one cycle.

## Test plan
- Reset, step 0→7 with sel=2, target=2 -> win=1 next cycle, score=1, streak=1, lives_left=3; holding step=7 for 5 cycles leaves score=1.
- Miss three rounds (sel=1, target=3), each separated by a clear step -> lives_left 2,1,0; game_over=1 and finish=1 after the third; later 7 and 0 steps change nothing and round_rst stays 0.
- sel=5, target=5 with NUM_SEL=4 -> counted as a miss, invalid_sel pulses 1 cycle, lives_left=2.
- SCORE_W=2 and 5 consecutive wins -> score and streak stick at 3.
- new_game in the same cycle as step 0→7 with a hit -> score=0, lives_left=3, win=0, round_rst=1 for one cycle.
- Assert rst while in RESULT with win=1 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/round_judge.sv
// Round judgement for the quadrant-guessing game: one verdict per round,
// saturating score and streak, lives counter and sticky game-over.
module round_judge #(
  parameter int SEL_W      = 3,
  parameter int NUM_SEL    = 4,
  parameter int STEP_W     = 4,
  parameter int JUDGE_STEP = 7,
  parameter int CLEAR_STEP = 0,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STEP_W-1:0]  step,
  input  logic [SEL_W-1:0]   icuadrante,
  input  logic [SEL_W-1:0]   cuadranterandom,
  input  logic               new_game,
  output logic               win,
  output logic               finish,
  output logic               round_rst,
  output logic               invalid_sel,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] streak,
  output logic [3:0]         lives_left,
  output logic               game_over
);

  typedef enum logic [1:0] {
    PLAY,
    RESULT,
    OVER
  } state_t;

  localparam logic [STEP_W-1:0]  JS    = STEP_W'(JUDGE_STEP);
  localparam logic [STEP_W-1:0]  CS    = STEP_W'(CLEAR_STEP);
  localparam logic [SEL_W:0]     NSEL  = (SEL_W+1)'(NUM_SEL);
  localparam logic [3:0]         LIV   = 4'(LIVES);
  localparam logic [SCORE_W-1:0] SMAX  = '1;

  state_t              state, state_n;
  logic [STEP_W-1:0]   step_q;
  logic                win_n, finish_n, round_rst_n, invalid_n, over_n;
  logic [SCORE_W-1:0]  score_n, streak_n;
  logic [3:0]          lives_n;
  logic                judge_evt, clear_evt, valid, hit;

  assign judge_evt = (step == JS) && (step_q != JS);
  assign clear_evt = (step == CS) && (step_q != CS);
  assign valid     = {1'b0, icuadrante} < NSEL;
  assign hit       = valid && (icuadrante == cuadranterandom);

  always_comb begin
    state_n     = state;
    win_n       = win;
    finish_n    = finish;
    round_rst_n = 1'b0;
    invalid_n   = 1'b0;
    score_n     = score;
    streak_n    = streak;
    lives_n     = lives_left;
    over_n      = game_over;
    if (new_game) begin
      state_n     = PLAY;
      win_n       = 1'b0;
      finish_n    = 1'b0;
      round_rst_n = 1'b1;
      score_n     = '0;
      streak_n    = '0;
      lives_n     = LIV;
      over_n      = 1'b0;
    end else begin
      unique case (state)
        PLAY: begin
          if (judge_evt) begin
            if (hit) begin
              win_n    = 1'b1;
              score_n  = (score == SMAX) ? score : score + 1'b1;
              streak_n = (streak == SMAX) ? streak : streak + 1'b1;
              state_n  = RESULT;
            end else begin
              finish_n  = 1'b1;
              streak_n  = '0;
              invalid_n = ~valid;
              if (lives_left <= 4'd1) begin
                lives_n = 4'd0;
                over_n  = 1'b1;
                state_n = OVER;
              end else begin
                lives_n = lives_left - 4'd1;
                state_n = RESULT;
              end
            end
          end else if (clear_evt) begin
            round_rst_n = 1'b1;
          end
        end
        RESULT: begin
          if (clear_evt) begin
            win_n       = 1'b0;
            finish_n    = 1'b0;
            round_rst_n = 1'b1;
            state_n     = PLAY;
          end
        end
        OVER: begin
          state_n = OVER;
        end
        default: state_n = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PLAY;
      step_q      <= CS;
      win         <= 1'b0;
      finish      <= 1'b0;
      round_rst   <= 1'b0;
      invalid_sel <= 1'b0;
      score       <= '0;
      streak      <= '0;
      lives_left  <= LIV;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      step_q      <= step;
      win         <= win_n;
      finish      <= finish_n;
      round_rst   <= round_rst_n;
      invalid_sel <= invalid_n;
      score       <= score_n;
      streak      <= streak_n;
      lives_left  <= lives_n;
      game_over   <= over_n;
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: directed scenarios with literal checks, then
// random steps/selections against a round-level behavioural model.
module tb_round_judge;

  localparam int SW = 2;
  localparam int SMAXI = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    step;
  logic [2:0]    icuadrante;
  logic [2:0]    cuadranterandom;
  logic          new_game;
  logic          win, finish, round_rst, invalid_sel, game_over;
  logic [SW-1:0] score, streak;
  logic [3:0]    lives_left;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  int m_prev, m_score, m_streak, m_lives;
  bit m_win, m_fin, m_rr, m_inv, m_go, m_judged;

  round_judge #(
    .SEL_W(3), .NUM_SEL(4), .STEP_W(4), .JUDGE_STEP(7),
    .CLEAR_STEP(0), .LIVES(3), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .icuadrante(icuadrante),
    .cuadranterandom(cuadranterandom), .new_game(new_game),
    .win(win), .finish(finish), .round_rst(round_rst),
    .invalid_sel(invalid_sel), .score(score), .streak(streak),
    .lives_left(lives_left), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_score = 0; m_streak = 0; m_lives = 3;
    m_win = 0; m_fin = 0; m_rr = 0; m_inv = 0; m_go = 0; m_judged = 0;
  endtask

  task automatic model_step(int st, int sel, int tgt, bit ng);
    bit je, ce;
    je = (st == 7) && (m_prev != 7);
    ce = (st == 0) && (m_prev != 0);
    m_prev = st;
    m_rr = 0;
    m_inv = 0;
    if (ng) begin
      m_score = 0; m_streak = 0; m_lives = 3;
      m_win = 0; m_fin = 0; m_go = 0; m_judged = 0; m_rr = 1;
    end else if (m_go) begin
      // game over: nothing moves until a new game
    end else if (!m_judged) begin
      if (je) begin
        m_judged = 1;
        if (sel == tgt && sel < 4) begin
          m_win = 1;
          m_score = (m_score + 1 > SMAXI) ? SMAXI : m_score + 1;
          m_streak = (m_streak + 1 > SMAXI) ? SMAXI : m_streak + 1;
        end else begin
          m_fin = 1;
          m_streak = 0;
          m_inv = (sel >= 4);
          m_lives = m_lives - 1;
          if (m_lives == 0) m_go = 1;
        end
      end else if (ce) begin
        m_rr = 1;
      end
    end else if (ce) begin
      m_win = 0; m_fin = 0; m_rr = 1; m_judged = 0;
    end
  endtask

  task automatic compare_all();
    chk("win", win, m_win);
    chk("finish", finish, m_fin);
    chk("round_rst", round_rst, m_rr);
    chk("invalid_sel", invalid_sel, m_inv);
    chk("score", score, m_score);
    chk("streak", streak, m_streak);
    chk("lives_left", lives_left, m_lives);
    chk("game_over", game_over, m_go);
  endtask

  // Called just after a negedge: drive, clock, compare at the next negedge.
  task automatic cyc(int st, int sel, int tgt, bit ng);
    step = 4'(st);
    icuadrante = 3'(sel);
    cuadranterandom = 3'(tgt);
    new_game = ng;
    model_step(st, sel, tgt, ng);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step = 0; icuadrante = 0; cuadranterandom = 0; new_game = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_win", win, 0);
    chk("rst_lives", lives_left, 3);
    chk("rst_score", score, 0);
    chk("rst_go", game_over, 0);
    compare_all();

    // Win a round, then hold the judge step
    cyc(7, 2, 2, 0);
    chk("t1_win", win, 1);
    chk("t1_score", score, 1);
    chk("t1_streak", streak, 1);
    chk("t1_lives", lives_left, 3);
    repeat (5) cyc(7, 2, 2, 0);
    chk("t1_hold_score", score, 1);

    // Three lost rounds exhaust the lives
    for (int r = 0; r < 3; r++) begin
      cyc(0, 0, 0, 0);
      chk("t2_rr", round_rst, 1);
      cyc(7, 1, 3, 0);
      chk("t2_lives", lives_left, 2 - r);
      chk("t2_finish", finish, 1);
    end
    chk("t2_go", game_over, 1);
    chk("t2_streak", streak, 0);
    cyc(0, 0, 0, 0);
    chk("t2_over_rr", round_rst, 0);
    cyc(7, 2, 2, 0);
    chk("t2_over_win", win, 0);
    chk("t2_over_fin", finish, 1);

    // New game, then an out-of-range selection matching an out-of-range target
    cyc(0, 0, 0, 1);
    chk("t3_ng_rr", round_rst, 1);
    chk("t3_ng_lives", lives_left, 3);
    cyc(7, 5, 5, 0);
    chk("t3_inv", invalid_sel, 1);
    chk("t3_lives", lives_left, 2);
    chk("t3_win", win, 0);
    cyc(7, 5, 5, 0);
    chk("t3_inv_pulse", invalid_sel, 0);

    // Five straight wins saturate the 2-bit counters
    for (int r = 0; r < 5; r++) begin
      cyc(0, 0, 0, 0);
      cyc(7, 3, 3, 0);
    end
    chk("t4_score", score, 3);
    chk("t4_streak", streak, 3);

    // new_game wins over a simultaneous hit judgement
    cyc(0, 0, 0, 0);
    cyc(7, 1, 1, 1);
    chk("t5_score", score, 0);
    chk("t5_lives", lives_left, 3);
    chk("t5_win", win, 0);
    chk("t5_rr", round_rst, 1);
    cyc(7, 1, 1, 0);
    chk("t5_rr_pulse", round_rst, 0);

    // Asynchronous reset while showing a win
    cyc(0, 0, 0, 0);
    cyc(7, 0, 0, 0);
    chk("t6_pre_win", win, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_win", win, 0);
    chk("t6_score", score, 0);
    chk("t6_streak", streak, 0);
    chk("t6_lives", lives_left, 3);
    chk("t6_fin", finish, 0);
    chk("t6_go", game_over, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random play
    for (int i = 0; i < 4000; i++) begin
      int st, sel, tgt;
      bit ng;
      case ($urandom_range(0, 4))
        0, 1: st = 0;
        2, 3: st = 7;
        default: st = $urandom_range(0, 15);
      endcase
      sel = $urandom_range(0, 5);
      tgt = ($urandom_range(0, 2) == 0) ? sel : $urandom_range(0, 5);
      ng = ($urandom_range(0, 49) == 0);
      cyc(st, sel, tgt, ng);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
